s_sclk_front: RTL and testbench

- Front-end stage of the SPI slave. Sits directly upstream of the MOSI shift receiver and the MISO shift transmitter.
- Synchronises raw pad signals sclk, cs_n and mosi into the system clock domain.
- Decodes SPI mode (CPOL/CPHA) into single-cycle sample and shift strobes.
- Tracks bit position within a word and flags frame completion or an aborted frame.

---
 rtl/s_sclk_front.sv | 209 ++++++++++++++++++++
 tb/tb_s_sclk_front.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_sclk_front.sv
// SPI slave front end: pad synchronisers, CPOL/CPHA edge decode,
// bit counting and frame start / done / abort strobes.
//
// Ports:
//   clk        in   system clock (at least 4x sclk)
//   rst        in   synchronous active-high reset
//   sclk_in    in   raw SPI clock from pad (async)
//   cs_n_in    in   raw chip select from pad, active-low (async)
//   mosi_in    in   raw MOSI from pad (async)
//   cs_n       out  synchronised chip select
//   mosi       out  MOSI bit aligned with sampl_en
//   sampl_en   out  one-cycle strobe per sample edge
//   shift_en   out  one-cycle strobe per drive edge (MISO)
//   load_en    out  one-cycle strobe at frame start (MISO load)
//   bit_cnt    out  bits sampled in the current word
//   frame_done out  pulse with the last sampled bit of a word
//   frame_err  out  pulse when cs_n rises mid-word
module s_sclk_front #(
    parameter int   data_width = 8,
    parameter int   cnt_width  = 4,
    parameter logic cpol       = 1'b0,
    parameter logic cpha       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk_in,
    input  logic                 cs_n_in,
    input  logic                 mosi_in,
    output logic                 cs_n,
    output logic                 mosi,
    output logic                 sampl_en,
    output logic                 shift_en,
    output logic                 load_en,
    output logic [cnt_width-1:0] bit_cnt,
    output logic                 frame_done,
    output logic                 frame_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
    localparam logic SAMPLE_ON_RISE = ~(cpol ^ cpha);

    localparam logic [cnt_width-1:0] LAST_BIT = cnt_width'(data_width - 1);

    // Synchronisers
    logic sclk_s1_q;
    logic sclk_s2_q;
    logic sclk_s3_q;
    logic sclk_s3_d;
    logic cs_s1_q;
    logic cs_s2_q;
    logic mosi_s1_q;
    logic mosi_s2_q;

    // FSM and counters
    state_t               state_q;
    state_t               state_d;
    logic [cnt_width-1:0] cnt_q;
    logic [cnt_width-1:0] cnt_d;
    logic                 supp_q;
    logic                 supp_d;

    // Registered outputs
    logic cs_q;
    logic mosi_q;
    logic samp_q;
    logic samp_d;
    logic shift_q;
    logic shift_d;
    logic load_q;
    logic load_d;
    logic done_q;
    logic done_d;
    logic err_q;
    logic err_d;

    // Edge decode
    logic rise;
    logic fall;
    logic samp_edge;
    logic drv_edge;

    assign rise      = sclk_s2_q & ~sclk_s3_q;
    assign fall      = ~sclk_s2_q & sclk_s3_q;
    assign samp_edge = SAMPLE_ON_RISE ? rise : fall;
    assign drv_edge  = SAMPLE_ON_RISE ? fall : rise;

    // Holding the history flop at the idle level while deselected means a
    // clock parked at the wrong level cannot look like an edge at frame start.
    assign sclk_s3_d = (state_q == IDLE) ? cpol : sclk_s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        supp_d  = supp_q;
        samp_d  = 1'b0;
        shift_d = 1'b0;
        load_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!cs_s2_q) begin
                    state_d = START;
                    load_d  = 1'b1;
                    // With cpha=1 bit 0 is already on MISO from the load,
                    // so the first drive edge must not shift.
                    supp_d  = cpha;
                end
            end

            START: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                if (cs_s2_q) begin
                    // Deselect wins over a coincident sample edge.
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = (cnt_q != '0);
                end else begin
                    if (samp_edge) begin
                        samp_d = 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            done_d = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (drv_edge) begin
                        if (supp_q) begin
                            supp_d = 1'b0;
                        end else begin
                            shift_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q <= cpol;
            sclk_s2_q <= cpol;
            sclk_s3_q <= cpol;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            supp_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            samp_q    <= 1'b0;
            shift_q   <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sclk_s1_q <= sclk_in;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s3_d;
            cs_s1_q   <= cs_n_in;
            cs_s2_q   <= cs_s1_q;
            mosi_s1_q <= mosi_in;
            mosi_s2_q <= mosi_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            supp_q    <= supp_d;
            cs_q      <= cs_s2_q;
            mosi_q    <= mosi_s2_q;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            load_q    <= load_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cs_n       = cs_q;
    assign mosi       = mosi_q;
    assign sampl_en   = samp_q;
    assign shift_en   = shift_q;
    assign load_en    = load_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_s_sclk_front.sv
// Bench for s_sclk_front: mode 0 and mode 3 instances driven by a
// behavioural SPI master, with a per-instance sample scoreboard.
module tb_s_sclk_front;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
    logic sclk3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0;

    logic       o0_cs_n, o0_mosi, o0_samp, o0_shift, o0_load, o0_done, o0_err;
    logic [3:0] o0_cnt;
    logic       o3_cs_n, o3_mosi, o3_samp, o3_shift, o3_load, o3_done, o3_err;
    logic [3:0] o3_cnt;

    always #5 clk = ~clk;

    s_sclk_front #(.data_width(8), .cnt_width(4), .cpol(1'b0), .cpha(1'b0)) u_m0 (
        .clk(clk), .rst(rst),
        .sclk_in(sclk0), .cs_n_in(cs0), .mosi_in(mosi0),
        .cs_n(o0_cs_n), .mosi(o0_mosi), .sampl_en(o0_samp),
        .shift_en(o0_shift), .load_en(o0_load), .bit_cnt(o0_cnt),
        .frame_done(o0_done), .frame_err(o0_err)
    );

    s_sclk_front #(.data_width(8), .cnt_width(4), .cpol(1'b1), .cpha(1'b1)) u_m3 (
        .clk(clk), .rst(rst),
        .sclk_in(sclk3), .cs_n_in(cs3), .mosi_in(mosi3),
        .cs_n(o3_cs_n), .mosi(o3_mosi), .sampl_en(o3_samp),
        .shift_en(o3_shift), .load_en(o3_load), .bit_cnt(o3_cnt),
        .frame_done(o3_done), .frame_err(o3_err)
    );

    typedef struct {
        logic b;
        logic d;
        int   c;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int ld0 = 0, sh0 = 0, dn0 = 0, er0 = 0, smp0 = 0;
    int ld3 = 0, sh3 = 0, dn3 = 0, er3 = 0, smp3 = 0;
    int b_ld0, b_sh0, b_dn0, b_er0, b_smp0;
    int b_ld3, b_sh3, b_dn3, b_er3, b_smp3;
    int ld_cyc0 = 0;
    int fall_cyc0 = 0;
    logic [7:0] rx0 = 8'h00;
    logic [7:0] rx3 = 8'h00;
    int pos0 = 0;
    int pos3 = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o0_samp && o0_shift) check("m0_excl", 1, 0);
        if (o0_load) begin
            ld0     <= ld0 + 1;
            ld_cyc0 <= cyc;
        end
        if (o0_shift) sh0 <= sh0 + 1;
        if (o0_err) begin
            er0 <= er0 + 1;
            check("m0_err_cnt", int'(o0_cnt), 0);
            check("m0_err_done", int'(o0_done), 0);
        end
        if (o0_done) begin
            dn0 <= dn0 + 1;
            if (!o0_samp) check("m0_done_wo_samp", 0, 1);
        end
        if (o0_samp) begin
            smp0 <= smp0 + 1;
            rx0  <= {rx0[6:0], o0_mosi};
            if (q0.size() == 0) begin
                check("m0_extra_samp", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("m0_mosi", int'(o0_mosi), int'(e.b));
                check("m0_done", int'(o0_done), int'(e.d));
                check("m0_cnt", int'(o0_cnt), e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (o3_samp && o3_shift) check("m3_excl", 1, 0);
        if (o3_load) ld3 <= ld3 + 1;
        if (o3_shift) sh3 <= sh3 + 1;
        if (o3_err) er3 <= er3 + 1;
        if (o3_done) begin
            dn3 <= dn3 + 1;
            if (!o3_samp) check("m3_done_wo_samp", 0, 1);
        end
        if (o3_samp) begin
            smp3 <= smp3 + 1;
            rx3  <= {rx3[6:0], o3_mosi};
            if (q3.size() == 0) begin
                check("m3_extra_samp", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("m3_mosi", int'(o3_mosi), int'(e.b));
                check("m3_done", int'(o3_done), int'(e.d));
                check("m3_cnt", int'(o3_cnt), e.c);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic half();
        tick(4);
    endtask

    task automatic snap0();
        b_ld0 = ld0; b_sh0 = sh0; b_dn0 = dn0; b_er0 = er0; b_smp0 = smp0;
    endtask

    task automatic snap3();
        b_ld3 = ld3; b_sh3 = sh3; b_dn3 = dn3; b_er3 = er3; b_smp3 = smp3;
    endtask

    task automatic push0(input logic b);
        exp_t e;
        e.b = b;
        e.d = (pos0 == 7);
        e.c = (pos0 == 7) ? 0 : pos0 + 1;
        q0.push_back(e);
        pos0 = (pos0 + 1) % 8;
    endtask

    task automatic push3(input logic b);
        exp_t e;
        e.b = b;
        e.d = (pos3 == 7);
        e.c = (pos3 == 7) ? 0 : pos3 + 1;
        q3.push_back(e);
        pos3 = (pos3 + 1) % 8;
    endtask

    // Mode 0: data set up while sclk low, sampled on rise, next bit on fall.
    task automatic send0(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi0 = b[7-i];
            push0(b[7-i]);
            half();
            sclk0 = 1'b1;
            half();
            sclk0 = 1'b0;
        end
    endtask

    // Mode 3: data driven on fall, sampled on rise, sclk idles high.
    task automatic send3(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sclk3 = 1'b0;
            mosi3 = b[7-i];
            push3(b[7-i]);
            half();
            sclk3 = 1'b1;
            half();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(4);
        check("rst_m0_cs_n", int'(o0_cs_n), 1);
        check("rst_m0_outs", int'({o0_mosi, o0_samp, o0_shift, o0_load,
                                   o0_done, o0_err, o0_cnt}), 0);
        check("rst_m3_cs_n", int'(o3_cs_n), 1);
        check("rst_m3_outs", int'({o3_mosi, o3_samp, o3_shift, o3_load,
                                   o3_done, o3_err, o3_cnt}), 0);
        rst = 1'b0;
        tick(6);

        // Mode 0, single byte 0xA5
        snap0();
        cs0 = 1'b0;
        fall_cyc0 = cyc;
        send0(8'hA5, 8);
        half();
        cs0 = 1'b1;
        tick(8);
        check("m0_load_cnt", ld0 - b_ld0, 1);
        check("m0_load_lat", ld_cyc0 - fall_cyc0, 3);
        check("m0_samples", smp0 - b_smp0, 8);
        check("m0_frames", dn0 - b_dn0, 1);
        check("m0_shifts", sh0 - b_sh0, 8);
        check("m0_errs", er0 - b_er0, 0);
        check("m0_rx", int'(rx0), 8'hA5);
        check("m0_idle_cnt", int'(o0_cnt), 0);
        check("m0_idle_cs", int'(o0_cs_n), 1);

        // Mode 3, single byte 0x3C
        snap3();
        cs3 = 1'b0;
        half();
        send3(8'h3C, 8);
        cs3 = 1'b1;
        tick(8);
        check("m3_load_cnt", ld3 - b_ld3, 1);
        check("m3_samples", smp3 - b_smp3, 8);
        check("m3_frames", dn3 - b_dn3, 1);
        check("m3_shifts", sh3 - b_sh3, 7);
        check("m3_errs", er3 - b_er3, 0);
        check("m3_rx", int'(rx3), 8'h3C);

        // Back-to-back words without deselect
        snap0();
        cs0 = 1'b0;
        send0(8'h12, 8);
        send0(8'h34, 8);
        half();
        cs0 = 1'b1;
        tick(8);
        check("b2b_load_cnt", ld0 - b_ld0, 1);
        check("b2b_samples", smp0 - b_smp0, 16);
        check("b2b_frames", dn0 - b_dn0, 2);
        check("b2b_shifts", sh0 - b_sh0, 16);
        check("b2b_errs", er0 - b_er0, 0);
        check("b2b_rx", int'(rx0), 8'h34);

        // Abort after 3 bits, then a clean byte
        snap0();
        cs0 = 1'b0;
        send0(8'hC3, 3);
        half();
        cs0 = 1'b1;
        pos0 = 0;
        tick(8);
        check("abort_errs", er0 - b_er0, 1);
        check("abort_frames", dn0 - b_dn0, 0);
        check("abort_samples", smp0 - b_smp0, 3);
        check("abort_cnt", int'(o0_cnt), 0);
        snap0();
        cs0 = 1'b0;
        send0(8'h5A, 8);
        half();
        cs0 = 1'b1;
        tick(8);
        check("post_abort_frames", dn0 - b_dn0, 1);
        check("post_abort_errs", er0 - b_er0, 0);
        check("post_abort_rx", int'(rx0), 8'h5A);

        // Reset in the middle of 0xFF
        cs0 = 1'b0;
        send0(8'hFF, 5);
        tick(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_cs_n", int'(o0_cs_n), 1);
        check("mrst_err", int'(o0_err), 0);
        check("mrst_outs", int'({o0_mosi, o0_samp, o0_shift, o0_load,
                                 o0_done, o0_err, o0_cnt}), 0);
        cs0 = 1'b1;
        mosi0 = 1'b0;
        sclk0 = 1'b0;
        tick(3);
        rst = 1'b0;
        pos0 = 0;
        check("mrst_q_empty", q0.size(), 0);
        tick(4);
        snap0();
        cs0 = 1'b0;
        send0(8'hFF, 8);
        half();
        cs0 = 1'b1;
        tick(8);
        check("post_rst_samples", smp0 - b_smp0, 8);
        check("post_rst_frames", dn0 - b_dn0, 1);
        check("post_rst_errs", er0 - b_er0, 0);
        check("post_rst_load", ld0 - b_ld0, 1);

        check("q0_empty", q0.size(), 0);
        check("q3_empty", q3.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
